axis_rr_scheduler: RTL and testbench

Packet-granular round-robin scheduler that shares one AXI4-Stream master port among NUM_SRC AXI4-Stream slave requesters inside the AXI4_Stream IP. Once a source is granted, the output stays locked to it until that source's TLAST beat completes. Software enables the block and masks sources through AXI-Lite registers. A status/statistics side-band feeds back to readable registers.

---
 rtl/axis_sched_pkg.sv | 17 +
 rtl/axis_rr_pick.sv | 30 +++
 rtl/axis_rr_scheduler.sv | 100 ++++++++++
 tb/tb_axis_rr_scheduler.sv | 323 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/axis_sched_pkg.sv
// Shared types and helpers for the AXI4-Stream round-robin scheduler.
package axis_sched_pkg;

  typedef enum logic {
    SCH_IDLE = 1'b0,
    SCH_XFER = 1'b1
  } sch_state_e;

  localparam int unsigned STAT_CNT_W = 32;

  // Index reached by stepping 'off' places forward from 'base', wrapping at n.
  function automatic int unsigned rot_idx(int unsigned base, int unsigned off,
                                          int unsigned n);
    return (base + off) % n;
  endfunction

endpackage

// File: rtl/axis_rr_pick.sv
// Combinational round-robin picker: first set request at or after rr_ptr.
module axis_rr_pick
  import axis_sched_pkg::*;
#(
  parameter int NUM_SRC  = 4,
  parameter int ID_WIDTH = $clog2(NUM_SRC)
) (
  input  logic [NUM_SRC-1:0]  req,
  input  logic [ID_WIDTH-1:0] rr_ptr,
  output logic                found,
  output logic [ID_WIDTH-1:0] pick
);

  int unsigned idx;

  // Scan upward from rr_ptr with wrap; the first hit wins.
  always_comb begin
    found = 1'b0;
    pick  = '0;
    idx   = 0;
    for (int unsigned i = 0; i < NUM_SRC; i++) begin
      idx = rot_idx(32'(rr_ptr), i, NUM_SRC);
      if (!found && req[idx]) begin
        found = 1'b1;
        pick  = ID_WIDTH'(idx);
      end
    end
  end

endmodule

// File: rtl/axis_rr_scheduler.sv
// Packet-granular round-robin scheduler sharing one AXI4-Stream master
// among NUM_SRC slave requesters; the grant is held until TLAST completes.
module axis_rr_scheduler
  import axis_sched_pkg::*;
#(
  parameter int NUM_SRC    = 4,
  parameter int DATA_WIDTH = 32,
  parameter int ID_WIDTH   = $clog2(NUM_SRC)
) (
  input  logic                          ACLK,
  input  logic                          ARESETN,
  input  logic                          cfg_enable,
  input  logic [NUM_SRC-1:0]            cfg_src_mask,
  input  logic [NUM_SRC-1:0]            s_axis_tvalid,
  output logic [NUM_SRC-1:0]            s_axis_tready,
  input  logic [NUM_SRC*DATA_WIDTH-1:0] s_axis_tdata,
  input  logic [NUM_SRC-1:0]            s_axis_tlast,
  output logic                          m_axis_tvalid,
  input  logic                          m_axis_tready,
  output logic [DATA_WIDTH-1:0]         m_axis_tdata,
  output logic                          m_axis_tlast,
  output logic [ID_WIDTH-1:0]           m_axis_tid,
  output logic                          stat_busy,
  output logic [ID_WIDTH-1:0]           stat_grant,
  output logic [STAT_CNT_W-1:0]         stat_pkt_cnt
);

  sch_state_e              state_q, state_d;
  logic [ID_WIDTH-1:0]     grant_q;
  logic [ID_WIDTH-1:0]     rr_ptr_q;
  logic [ID_WIDTH-1:0]     pick;
  logic                    found;
  logic                    eop;
  logic [NUM_SRC-1:0]      cand;
  logic [STAT_CNT_W-1:0]   pkt_cnt_q;

  // Config only gates new arbitration; a packet in flight is never aborted.
  assign cand = cfg_enable ? (s_axis_tvalid & cfg_src_mask) : '0;

  axis_rr_pick #(
    .NUM_SRC  (NUM_SRC),
    .ID_WIDTH (ID_WIDTH)
  ) u_pick (
    .req    (cand),
    .rr_ptr (rr_ptr_q),
    .found  (found),
    .pick   (pick)
  );

  // FSM state register.
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) state_q <= SCH_IDLE;
    else          state_q <= state_d;
  end

  // Next-state logic and the XFER pass-through mux.
  always_comb begin
    state_d       = state_q;
    s_axis_tready = '0;
    m_axis_tvalid = 1'b0;
    m_axis_tdata  = '0;
    m_axis_tlast  = 1'b0;
    eop           = 1'b0;
    case (state_q)
      SCH_IDLE: begin
        if (found) state_d = SCH_XFER;
      end
      SCH_XFER: begin
        m_axis_tvalid          = s_axis_tvalid[grant_q];
        m_axis_tdata           = s_axis_tdata[grant_q*DATA_WIDTH +: DATA_WIDTH];
        m_axis_tlast           = s_axis_tlast[grant_q];
        s_axis_tready[grant_q] = m_axis_tready;
        eop                    = m_axis_tvalid & m_axis_tready & m_axis_tlast;
        if (eop) state_d = SCH_IDLE;
      end
      default: state_d = SCH_IDLE;
    endcase
  end

  // Grant capture, rotation pointer advance and completed-packet counter.
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      grant_q   <= '0;
      rr_ptr_q  <= '0;
      pkt_cnt_q <= '0;
    end else begin
      if (state_q == SCH_IDLE && found) grant_q <= pick;
      if (eop) begin
        rr_ptr_q  <= (grant_q == ID_WIDTH'(NUM_SRC - 1)) ? '0 : grant_q + 1'b1;
        pkt_cnt_q <= pkt_cnt_q + 1'b1;
      end
    end
  end

  assign m_axis_tid   = grant_q;
  assign stat_grant   = grant_q;
  assign stat_busy    = (state_q == SCH_XFER);
  assign stat_pkt_cnt = pkt_cnt_q;

endmodule

// File: tb/tb_axis_rr_scheduler.sv
// Self-checking bench for axis_rr_scheduler: a vector table for per-cycle
// arbitration behaviour plus directed multi-cycle sequences.
`timescale 1ns/1ps
module tb_axis_rr_scheduler;

  localparam int N  = 4;
  localparam int DW = 32;
  localparam int IW = 2;

  logic            ACLK = 1'b0;
  logic            ARESETN;
  logic            cfg_enable;
  logic [N-1:0]    cfg_src_mask;
  logic [N-1:0]    s_axis_tvalid;
  logic [N-1:0]    s_axis_tready;
  logic [N*DW-1:0] s_axis_tdata;
  logic [N-1:0]    s_axis_tlast;
  logic            m_axis_tvalid;
  logic            m_axis_tready;
  logic [DW-1:0]   m_axis_tdata;
  logic            m_axis_tlast;
  logic [IW-1:0]   m_axis_tid;
  logic            stat_busy;
  logic [IW-1:0]   stat_grant;
  logic [31:0]     stat_pkt_cnt;

  axis_rr_scheduler #(.NUM_SRC(N), .DATA_WIDTH(DW), .ID_WIDTH(IW)) dut (
    .ACLK          (ACLK),
    .ARESETN       (ARESETN),
    .cfg_enable    (cfg_enable),
    .cfg_src_mask  (cfg_src_mask),
    .s_axis_tvalid (s_axis_tvalid),
    .s_axis_tready (s_axis_tready),
    .s_axis_tdata  (s_axis_tdata),
    .s_axis_tlast  (s_axis_tlast),
    .m_axis_tvalid (m_axis_tvalid),
    .m_axis_tready (m_axis_tready),
    .m_axis_tdata  (m_axis_tdata),
    .m_axis_tlast  (m_axis_tlast),
    .m_axis_tid    (m_axis_tid),
    .stat_busy     (stat_busy),
    .stat_grant    (stat_grant),
    .stat_pkt_cnt  (stat_pkt_cnt)
  );

  always #5 ACLK = ~ACLK;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  // Source model: each enabled source streams packets of gen_len beats.
  logic [N-1:0] gen_valid;
  int           gen_len;
  bit           plain;
  int           beat [N];
  int           pnum [N];

  task automatic drive_src();
    for (int i = 0; i < N; i++) begin
      s_axis_tvalid[i] = gen_valid[i];
      s_axis_tlast[i]  = (beat[i] == gen_len - 1);
      s_axis_tdata[i*DW +: DW] = plain ? 32'(beat[i] + 1)
                                       : {8'(i), 8'(pnum[i]), 16'(beat[i])};
    end
  endtask

  // Output monitor state.
  bit   mon_en, gap_watch, mask_watch, bp_watch, pat_en;
  int   mon_len, cyc, out_beat, out_pkts, n_beats, last_eop, pat_k;
  int   exp_pkt [N];
  int   tid_q [$];
  bit   bad_mask, bad_bp;
  logic smv, smr, sml, smbusy;
  logic [31:0]   smd;
  logic [IW-1:0] smid;
  logic [N-1:0]  ssr;
  logic [3:0]    pat;

  task automatic cycle();
    logic [31:0] exp_d;
    @(negedge ACLK);
    cyc++;
    smv = m_axis_tvalid; smr = m_axis_tready; sml = m_axis_tlast;
    smd = m_axis_tdata;  smid = m_axis_tid;   ssr = s_axis_tready;
    smbusy = stat_busy;
    if (mask_watch && (ssr[0] || ssr[2])) bad_mask = 1'b1;
    if (bp_watch && ssr !== ((smbusy && smr) ? 4'b0100 : 4'b0000)) bad_bp = 1'b1;
    if (mon_en && smv && smr) begin
      if (out_beat == 0) begin
        if (gap_watch && out_pkts > 0) check("gap", 32'(cyc - last_eop - 1), 32'd1);
        tid_q.push_back(int'(smid));
      end
      exp_d = plain ? 32'(out_beat + 1) : {8'(smid), 8'(exp_pkt[smid]), 16'(out_beat)};
      check("beat_data", smd, exp_d);
      check("beat_last", 32'(sml), 32'(out_beat == mon_len - 1));
      n_beats++;
      if (sml) begin
        out_beat = 0;
        out_pkts++;
        exp_pkt[smid]++;
        last_eop = cyc;
      end else begin
        out_beat++;
      end
    end
    @(posedge ACLK);
    #1;
    for (int i = 0; i < N; i++) begin
      if (ssr[i] && s_axis_tvalid[i]) begin
        if (beat[i] == gen_len - 1) begin
          beat[i] = 0;
          pnum[i]++;
        end else begin
          beat[i]++;
        end
      end
    end
    if (pat_en) begin
      m_axis_tready = pat[pat_k % 4];
      pat_k++;
    end
    drive_src();
  endtask

  task automatic run_until_pkts(input int n, input int budget, input string name);
    int k = 0;
    while (out_pkts < n && k < budget) begin
      cycle();
      k++;
    end
    check(name, 32'(out_pkts), 32'(n));
  endtask

  task automatic run_until_beat(input int b, input int budget, input string name);
    int k = 0;
    while (out_beat != b && k < budget) begin
      cycle();
      k++;
    end
    check(name, 32'(out_beat), 32'(b));
  endtask

  task automatic do_reset();
    #2 ARESETN = 1'b0;
    cfg_enable = 1'b1; cfg_src_mask = 4'hF; m_axis_tready = 1'b1;
    gen_valid = '0; gen_len = 3; plain = 1'b0;
    mon_en = 1'b1; gap_watch = 1'b0; mask_watch = 1'b0; bp_watch = 1'b0; pat_en = 1'b0;
    mon_len = 3; out_beat = 0; out_pkts = 0; n_beats = 0; last_eop = 0; pat_k = 0;
    bad_mask = 1'b0; bad_bp = 1'b0;
    tid_q.delete();
    for (int i = 0; i < N; i++) begin
      beat[i] = 0; pnum[i] = 0; exp_pkt[i] = 0;
    end
    drive_src();
    repeat (2) @(posedge ACLK);
    #1 ARESETN = 1'b1;
  endtask

  typedef struct {
    logic         en;
    logic [N-1:0] mask;
    logic [N-1:0] valid;
    logic         rdy;
    logic         busy;
    logic         mv;
    logic [IW-1:0] tid;
    logic [N-1:0] sr;
    logic [31:0]  data;
  } vec_t;

  vec_t vt [13];

  initial begin
    // Per-cycle arbitration table: single-beat packets, source i data = 0xA0+i.
    vt[0]  = '{1'b1, 4'hF, 4'hF, 1'b1, 1'b0, 1'b0, 2'd0, 4'b0000, 32'h0};
    vt[1]  = '{1'b1, 4'hF, 4'hF, 1'b1, 1'b1, 1'b1, 2'd0, 4'b0001, 32'hA0};
    vt[2]  = '{1'b1, 4'hF, 4'hF, 1'b1, 1'b0, 1'b0, 2'd0, 4'b0000, 32'h0};
    vt[3]  = '{1'b1, 4'hF, 4'hF, 1'b1, 1'b1, 1'b1, 2'd1, 4'b0010, 32'hA1};
    vt[4]  = '{1'b0, 4'hF, 4'hF, 1'b1, 1'b0, 1'b0, 2'd1, 4'b0000, 32'h0};
    vt[5]  = '{1'b1, 4'h9, 4'hF, 1'b1, 1'b0, 1'b0, 2'd1, 4'b0000, 32'h0};
    vt[6]  = '{1'b1, 4'h9, 4'hF, 1'b1, 1'b1, 1'b1, 2'd3, 4'b1000, 32'hA3};
    vt[7]  = '{1'b1, 4'hF, 4'h0, 1'b1, 1'b0, 1'b0, 2'd3, 4'b0000, 32'h0};
    vt[8]  = '{1'b1, 4'hF, 4'h4, 1'b1, 1'b0, 1'b0, 2'd3, 4'b0000, 32'h0};
    vt[9]  = '{1'b1, 4'hF, 4'h4, 1'b0, 1'b1, 1'b1, 2'd2, 4'b0000, 32'hA2};
    vt[10] = '{1'b1, 4'hF, 4'h4, 1'b1, 1'b1, 1'b1, 2'd2, 4'b0100, 32'hA2};
    vt[11] = '{1'b1, 4'hF, 4'h3, 1'b1, 1'b0, 1'b0, 2'd2, 4'b0000, 32'h0};
    vt[12] = '{1'b1, 4'hF, 4'h3, 1'b1, 1'b1, 1'b1, 2'd0, 4'b0001, 32'hA0};
    pat = 4'b1001;  // tready per cycle: 1,0,0,1 (bit k used at step k)

    // Reset held 100 ns with every source valid.
    ARESETN = 1'b0;
    cfg_enable = 1'b1; cfg_src_mask = 4'hF; m_axis_tready = 1'b1;
    gen_valid = 4'hF; gen_len = 3; plain = 1'b0;
    mon_en = 1'b1; gap_watch = 1'b1; mask_watch = 1'b0; bp_watch = 1'b0; pat_en = 1'b0;
    mon_len = 3; cyc = 0; out_beat = 0; out_pkts = 0; n_beats = 0; last_eop = 0; pat_k = 0;
    bad_mask = 1'b0; bad_bp = 1'b0;
    for (int i = 0; i < N; i++) begin
      beat[i] = 0; pnum[i] = 0; exp_pkt[i] = 0;
    end
    drive_src();
    #100;
    check("rst_m_tvalid", 32'(m_axis_tvalid), 32'd0);
    check("rst_s_tready", 32'(s_axis_tready), 32'd0);
    check("rst_m_tdata",  m_axis_tdata, 32'd0);
    check("rst_m_tlast",  32'(m_axis_tlast), 32'd0);
    check("rst_m_tid",    32'(m_axis_tid), 32'd0);
    check("rst_busy",     32'(stat_busy), 32'd0);
    check("rst_grant",    32'(stat_grant), 32'd0);
    check("rst_pkt_cnt",  stat_pkt_cnt, 32'd0);
    @(posedge ACLK);
    #1 ARESETN = 1'b1;

    // Fairness: all four sources, 3-beat packets, order must rotate from 0.
    run_until_pkts(8, 80, "fair_pkts");
    for (int k = 0; k < 8; k++)
      check($sformatf("fair_order%0d", k),
            32'(tid_q.size() > k ? tid_q[k] : 99), 32'(k % 4));
    check("fair_pkt_cnt", stat_pkt_cnt, 32'd8);

    // Table-driven per-cycle arbitration.
    do_reset();
    mon_en = 1'b0;
    for (int k = 0; k < 13; k++) begin
      cfg_enable = vt[k].en; cfg_src_mask = vt[k].mask;
      s_axis_tvalid = vt[k].valid; m_axis_tready = vt[k].rdy;
      s_axis_tlast = 4'hF;
      for (int i = 0; i < N; i++) s_axis_tdata[i*DW +: DW] = 32'hA0 + 32'(i);
      @(negedge ACLK);
      check($sformatf("vec%0d_busy", k),  32'(stat_busy),     32'(vt[k].busy));
      check($sformatf("vec%0d_mvalid", k), 32'(m_axis_tvalid), 32'(vt[k].mv));
      check($sformatf("vec%0d_tid", k),   32'(m_axis_tid),    32'(vt[k].tid));
      check($sformatf("vec%0d_sready", k), 32'(s_axis_tready), 32'(vt[k].sr));
      check($sformatf("vec%0d_data", k),  m_axis_tdata,       vt[k].data);
      check($sformatf("vec%0d_last", k),  32'(m_axis_tlast),  32'(vt[k].mv));
      @(posedge ACLK);
      #1;
    end

    // Mask 0b1010: only sources 1 and 3, alternating.
    do_reset();
    cfg_src_mask = 4'b1010; gen_valid = 4'hF; gap_watch = 1'b1; mask_watch = 1'b1;
    drive_src();
    run_until_pkts(4, 40, "mask_pkts");
    for (int k = 0; k < 4; k++)
      check($sformatf("mask_order%0d", k),
            32'(tid_q.size() > k ? tid_q[k] : 99), (k % 2 == 0) ? 32'd1 : 32'd3);
    check("mask_tready02", 32'(bad_mask), 32'd0);

    // Backpressure: 4-beat packet from source 2, tready pattern 1,0,0,1.
    do_reset();
    gen_valid = 4'b0100; gen_len = 4; mon_len = 4; plain = 1'b1;
    pat_en = 1'b1; bp_watch = 1'b1;
    drive_src();
    run_until_pkts(1, 40, "bp_pkt");
    check("bp_beats", 32'(n_beats), 32'd4);
    check("bp_tid", 32'(tid_q.size() > 0 ? tid_q[0] : 99), 32'd2);
    check("bp_tready_follow", 32'(bad_bp), 32'd0);

    // Disable mid-packet: 8-beat packet completes, then no grants until re-enabled.
    do_reset();
    gen_valid = 4'b0010; gen_len = 8; mon_len = 8; plain = 1'b1;
    drive_src();
    run_until_beat(2, 30, "dis_reach_beat2");
    cfg_enable = 1'b0;
    run_until_pkts(1, 30, "dis_complete");
    begin
      bit bad_idle = 1'b0;
      repeat (6) begin
        cycle();
        if (smbusy) bad_idle = 1'b1;
      end
      check("dis_stays_idle", 32'(bad_idle), 32'd0);
    end
    cfg_enable = 1'b1;
    begin
      int k = 0;
      smbusy = 1'b0;
      while (!smbusy && k < 5) begin
        cycle();
        k++;
      end
      check("dis_resume", 32'(smbusy), 32'd1);
    end

    // Counter wrap via preload.
    do_reset();
    force dut.pkt_cnt_q = 32'hFFFF_FFFF;
    #1 release dut.pkt_cnt_q;
    check("cnt_preload", stat_pkt_cnt, 32'hFFFF_FFFF);
    gen_valid = 4'b0001; gen_len = 1; mon_len = 1;
    drive_src();
    run_until_pkts(1, 10, "wrap_pkt");
    check("cnt_wrap", stat_pkt_cnt, 32'd0);

    // Reset asserted during beat 3 of an 8-beat packet from source 3.
    do_reset();
    gen_valid = 4'b1000; gen_len = 8; mon_len = 8; plain = 1'b1;
    drive_src();
    run_until_beat(2, 30, "mrst_reach_beat3");
    #2 ARESETN = 1'b0;
    #1;
    check("mrst_busy",     32'(stat_busy), 32'd0);
    check("mrst_m_tvalid", 32'(m_axis_tvalid), 32'd0);
    check("mrst_s_tready", 32'(s_axis_tready), 32'd0);
    check("mrst_m_tdata",  m_axis_tdata, 32'd0);
    check("mrst_m_tlast",  32'(m_axis_tlast), 32'd0);
    check("mrst_m_tid",    32'(m_axis_tid), 32'd0);
    check("mrst_grant",    32'(stat_grant), 32'd0);
    check("mrst_pkt_cnt",  stat_pkt_cnt, 32'd0);
    @(posedge ACLK);
    #1 ARESETN = 1'b1;

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
